regfile_mp: RTL and testbench

- Parametrised successor to the core's fixed 32x32, 2-read/1-write register file.
- Width, register count and read-port count are configurable.
- Adds:
  - optional write-to-read bypass;
  - optional hardwired-zero register 0;
  - synchronous clear of the whole array;
  - per-register busy scoreboard, so the decode stage can detect RAW hazards on in-flight writes.
- Sits between decode (read and reserve) and writeback (write and clear busy).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 74 +++++++
 tb/tb_regfile_mp.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_AW       = $clog2(DEF_NUM_REGS);

    // Types at the default configuration; parametrised instances size their own signals.
    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xdata_t;

    function automatic bit is_pow2(int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bundle of the multi-port register file.
// The master drives reads, writes and reservations; the slave (the register file)
// returns read data and the busy scoreboard.
interface regfile_mp_intf
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN         = DEF_XLEN,
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned NUM_RD_PORTS = 2
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic                wr_en;
    logic [AW-1:0]       wr_reg;
    logic [XLEN-1:0]     wr_data;

    logic [AW-1:0]       rd_reg  [NUM_RD_PORTS];
    logic [XLEN-1:0]     rd_data [NUM_RD_PORTS];

    logic                rsv_en;
    logic [AW-1:0]       rsv_reg;
    logic [NUM_REGS-1:0] busy;

    modport master (
        output wr_en, wr_reg, wr_data, rd_reg, rsv_en, rsv_reg,
        input  rd_data, busy
    );

    modport slave (
        input  wr_en, wr_reg, wr_data, rd_reg, rsv_en, rsv_reg,
        output rd_data, busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: decode reserves a destination, writeback clears it.
// A reserve and a clear of the same register in one cycle leave it busy, since the
// reserve belongs to a newer producer than the write that is retiring.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rsv_en,
    input  logic [$clog2(NUM_REGS)-1:0] rsv_reg,
    input  logic                        clr_en,
    input  logic [$clog2(NUM_REGS)-1:0] clr_reg,
    output logic [NUM_REGS-1:0]         busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear first, then set, so the reserve takes priority.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_reg] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_reg] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy register; reset drops every in-flight reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass, optional
// hardwired-zero register 0, synchronous whole-array clear and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN         = DEF_XLEN,
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter bit          BYPASS       = 1'b1,
    parameter bit          ZERO_REG     = 1'b1
) (
    input logic            clk,
    input logic            rst,
    regfile_mp_intf.slave  bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    if (!is_pow2(NUM_REGS) || (NUM_REGS < 2)) begin : g_bad_num_regs
        $error("regfile_mp: NUM_REGS must be a power of two and at least 2");
    end
    if ((NUM_RD_PORTS < 1) || (NUM_RD_PORTS > 4)) begin : g_bad_num_rd_ports
        $error("regfile_mp: NUM_RD_PORTS must be between 1 and 4");
    end

    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic                wr_ok;
    logic [NUM_REGS-1:0] busy_vec;

    // Writes to the hardwired zero register are dropped so entry 0 stays cleared.
    assign wr_ok = bus.wr_en && !(ZERO_REG && (bus.wr_reg == '0));

    // Storage array: synchronous clear of every entry, otherwise accept the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_ok) begin
            mem_q[bus.wr_reg] <= bus.wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [XLEN-1:0] rd_val;

        // Array read, then same-cycle forwarding, then the hardwired zero on top.
        always_comb begin
            rd_val = mem_q[bus.rd_reg[p]];
            if (BYPASS && bus.wr_en && (bus.wr_reg == bus.rd_reg[p])) begin
                rd_val = bus.wr_data;
            end
            if (ZERO_REG && (bus.rd_reg[p] == '0)) begin
                rd_val = '0;
            end
        end

        assign bus.rd_data[p] = rd_val;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .rsv_en  (bus.rsv_en),
        .rsv_reg (bus.rsv_reg),
        .clr_en  (bus.wr_en),
        .clr_reg (bus.wr_reg),
        .busy    (busy_vec)
    );

    assign bus.busy = busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (32x32/2 ports with bypass and zero register,
// 64x16/4 ports without either) checked every cycle against a behavioural model,
// plus literal expectations for the directed scenarios.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_mp_intf #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2)) a_if ();
    regfile_mp_intf #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(4)) b_if ();

    regfile_mp #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    regfile_mp #(
        .XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(4), .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    // ---------------- behavioural model ----------------
    xdata_t      ma [32];
    logic [31:0] ba;
    logic [63:0] mb [16];
    logic [15:0] bb;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 32; i++) ma[i] = '0;
                for (int i = 0; i < 16; i++) mb[i] = '0;
                ba = '0;
                bb = '0;
            end else begin
                // Instance A: register 0 is constant zero and never busy.
                if (a_if.wr_en && a_if.wr_reg != 0) ma[a_if.wr_reg] = a_if.wr_data;
                if (a_if.wr_en) ba[a_if.wr_reg] = 1'b0;
                if (a_if.rsv_en && a_if.rsv_reg != 0) ba[a_if.rsv_reg] = 1'b1;
                // Instance B: every register is ordinary.
                if (b_if.wr_en) mb[b_if.wr_reg] = b_if.wr_data;
                if (b_if.wr_en) bb[b_if.wr_reg] = 1'b0;
                if (b_if.rsv_en) bb[b_if.rsv_reg] = 1'b1;
            end
        end
    end

    function automatic logic [63:0] exp_a(int p);
        reg_addr_t r;
        r = a_if.rd_reg[p];
        if (r == 0) return 64'h0;
        if (a_if.wr_en && a_if.wr_reg == r) return {32'h0, a_if.wr_data};
        return {32'h0, ma[r]};
    endfunction

    function automatic logic [63:0] exp_b(int p);
        return mb[b_if.rd_reg[p]];
    endfunction

    // ---------------- literal expectations ----------------
    typedef struct packed {
        logic        is_b;
        logic [1:0]  kind;   // 0: rd_data[idx], 1: busy[idx], 2: whole busy vector
        logic [4:0]  idx;
        logic [7:0]  tag;
        logic [63:0] exp;
    } lit_t;

    lit_t lit_tab [16];
    int   lit_n     = 0;
    int   lit_stamp = -1;
    int   cyc       = 0;
    bit   chk_en    = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lit_actual(lit_t l);
        logic [63:0] v;
        v = 'x;
        case (l.kind)
            2'd0: begin
                if (l.is_b) begin
                    for (int p = 0; p < 4; p++) if (p == int'(l.idx)) v = b_if.rd_data[p];
                end else begin
                    for (int p = 0; p < 2; p++) if (p == int'(l.idx)) v = {32'h0, a_if.rd_data[p]};
                end
            end
            2'd1: v = l.is_b ? {63'h0, b_if.busy[l.idx[3:0]]} : {63'h0, a_if.busy[l.idx]};
            default: v = l.is_b ? {48'h0, b_if.busy} : {32'h0, a_if.busy};
        endcase
        return v;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int p = 0; p < 2; p++)
                    check($sformatf("a_rd%0d@%0d", p, cyc), {32'h0, a_if.rd_data[p]}, exp_a(p));
                check($sformatf("a_busy@%0d", cyc), {32'h0, a_if.busy}, {32'h0, ba});
                for (int p = 0; p < 4; p++)
                    check($sformatf("b_rd%0d@%0d", p, cyc), b_if.rd_data[p], exp_b(p));
                check($sformatf("b_busy@%0d", cyc), {48'h0, b_if.busy}, {48'h0, bb});
                if (lit_stamp == cyc) begin
                    for (int i = 0; i < lit_n; i++)
                        check($sformatf("lit%0d_%s_k%0d_%0d@%0d", lit_tab[i].tag,
                                        lit_tab[i].is_b ? "b" : "a", lit_tab[i].kind,
                                        lit_tab[i].idx, cyc),
                              lit_actual(lit_tab[i]), lit_tab[i].exp);
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
        lit_n     = 0;
        lit_stamp = cyc;
    endtask

    task automatic add_lit(bit is_b, int kind, int idx, logic [63:0] exp, int tag);
        lit_tab[lit_n] = '{is_b: is_b, kind: 2'(kind), idx: 5'(idx), tag: 8'(tag), exp: exp};
        lit_n++;
    endtask

    task automatic drive_a(bit we, int wr, logic [31:0] wd, bit re, int rr);
        a_if.wr_en   = we;
        a_if.wr_reg  = reg_addr_t'(wr);
        a_if.wr_data = wd;
        a_if.rsv_en  = re;
        a_if.rsv_reg = reg_addr_t'(rr);
    endtask

    task automatic drive_b(bit we, int wr, logic [63:0] wd, bit re, int rr);
        b_if.wr_en   = we;
        b_if.wr_reg  = 4'(wr);
        b_if.wr_data = wd;
        b_if.rsv_en  = re;
        b_if.rsv_reg = 4'(rr);
    endtask

    task automatic read_all(int ra, int rb);
        for (int p = 0; p < 2; p++) a_if.rd_reg[p] = reg_addr_t'(ra);
        for (int p = 0; p < 4; p++) b_if.rd_reg[p] = 4'(rb);
    endtask

    task automatic idle();
        drive_a(1'b0, 0, 32'h0, 1'b0, 0);
        drive_b(1'b0, 0, 64'h0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        read_all(0, 0);
        next_cycle();
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: after reset every register reads zero and nothing is busy.
        for (int r = 0; r < 32; r++) begin
            next_cycle();
            a_if.rd_reg[0] = reg_addr_t'(r);
            a_if.rd_reg[1] = reg_addr_t'(31 - r);
            for (int p = 0; p < 4; p++) b_if.rd_reg[p] = 4'(r + p);
            add_lit(1'b0, 0, 0, 64'h0, 1);
            add_lit(1'b0, 0, 1, 64'h0, 1);
            add_lit(1'b0, 2, 0, 64'h0, 1);
            for (int p = 0; p < 4; p++) add_lit(1'b1, 0, p, 64'h0, 1);
            add_lit(1'b1, 2, 0, 64'h0, 1);
        end

        // 2: write reg 5 while reading it; A forwards, B shows the old value.
        next_cycle();
        read_all(5, 5);
        drive_a(1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
        drive_b(1'b1, 5, 64'hDEADBEEF, 1'b0, 0);
        add_lit(1'b0, 0, 0, 64'hDEADBEEF, 2);
        add_lit(1'b1, 0, 0, 64'h0, 2);
        next_cycle();
        idle();
        add_lit(1'b0, 0, 0, 64'hDEADBEEF, 2);
        add_lit(1'b1, 0, 0, 64'hDEADBEEF, 2);

        // 3: write reg 0 with all ones; zero register on A only.
        next_cycle();
        read_all(0, 0);
        drive_a(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0);
        drive_b(1'b1, 0, 64'hFFFFFFFF, 1'b0, 0);
        add_lit(1'b0, 0, 0, 64'h0, 3);
        add_lit(1'b0, 0, 1, 64'h0, 3);
        add_lit(1'b1, 0, 0, 64'h0, 3);
        next_cycle();
        idle();
        for (int p = 0; p < 2; p++) add_lit(1'b0, 0, p, 64'h0, 3);
        for (int p = 0; p < 4; p++) add_lit(1'b1, 0, p, 64'hFFFFFFFF, 3);

        // 4: scoreboard on reg 7, then reserving reg 0.
        next_cycle();
        drive_a(1'b0, 0, 32'h0, 1'b1, 7);
        drive_b(1'b0, 0, 64'h0, 1'b1, 7);
        add_lit(1'b0, 1, 7, 64'h0, 4);
        add_lit(1'b1, 1, 7, 64'h0, 4);
        next_cycle();
        drive_a(1'b1, 7, 32'h77, 1'b1, 7);
        drive_b(1'b1, 7, 64'h77, 1'b1, 7);
        add_lit(1'b0, 1, 7, 64'h1, 4);
        add_lit(1'b1, 1, 7, 64'h1, 4);
        next_cycle();
        drive_a(1'b1, 7, 32'h78, 1'b0, 0);
        drive_b(1'b1, 7, 64'h78, 1'b0, 0);
        add_lit(1'b0, 1, 7, 64'h1, 4);
        add_lit(1'b1, 1, 7, 64'h1, 4);
        next_cycle();
        idle();
        add_lit(1'b0, 1, 7, 64'h0, 4);
        add_lit(1'b1, 1, 7, 64'h0, 4);
        next_cycle();
        drive_a(1'b0, 0, 32'h0, 1'b1, 0);
        drive_b(1'b0, 0, 64'h0, 1'b1, 0);
        next_cycle();
        idle();
        add_lit(1'b0, 1, 0, 64'h0, 4);
        add_lit(1'b1, 1, 0, 64'h1, 4);
        next_cycle();
        drive_b(1'b1, 0, 64'h5, 1'b0, 0);
        add_lit(1'b1, 1, 0, 64'h1, 4);
        next_cycle();
        idle();
        read_all(0, 0);
        add_lit(1'b1, 1, 0, 64'h0, 4);
        add_lit(1'b1, 0, 0, 64'h5, 4);
        add_lit(1'b0, 0, 0, 64'h0, 4);

        // 5: load registers with their index, then reset during a write to reg 3.
        for (int r = 1; r < 32; r++) begin
            next_cycle();
            drive_a(1'b1, r, 32'(r), r == 20, 20);
            drive_b(r < 16, r, 64'(r), r == 20, 12);
        end
        next_cycle();
        idle();
        a_if.rd_reg[0] = 5'd3;
        a_if.rd_reg[1] = 5'd20;
        b_if.rd_reg[0] = 4'd3;
        add_lit(1'b0, 0, 0, 64'h3, 5);
        add_lit(1'b0, 0, 1, 64'd20, 5);
        add_lit(1'b0, 1, 20, 64'h1, 5);
        add_lit(1'b1, 0, 0, 64'h3, 5);
        add_lit(1'b1, 1, 12, 64'h1, 5);
        next_cycle();
        rst = 1'b1;
        drive_a(1'b1, 3, 32'h1234, 1'b1, 9);
        drive_b(1'b1, 3, 64'h1234, 1'b1, 9);
        add_lit(1'b0, 0, 0, 64'h1234, 5);
        add_lit(1'b1, 0, 0, 64'h3, 5);
        for (int r = 0; r < 32; r++) begin
            next_cycle();
            rst = 1'b0;
            idle();
            a_if.rd_reg[0] = reg_addr_t'(r);
            a_if.rd_reg[1] = reg_addr_t'(r ^ 3);
            for (int p = 0; p < 4; p++) b_if.rd_reg[p] = 4'(r + p);
            add_lit(1'b0, 0, 0, 64'h0, 5);
            add_lit(1'b0, 0, 1, 64'h0, 5);
            add_lit(1'b0, 2, 0, 64'h0, 5);
            for (int p = 0; p < 4; p++) add_lit(1'b1, 0, p, 64'h0, 5);
            add_lit(1'b1, 2, 0, 64'h0, 5);
        end

        // 6: all four wide ports read reg 9.
        next_cycle();
        drive_b(1'b1, 9, 64'hA5A5_0000_FFFF_0001, 1'b0, 0);
        next_cycle();
        idle();
        read_all(9, 9);
        for (int p = 0; p < 4; p++) add_lit(1'b1, 0, p, 64'hA5A5_0000_FFFF_0001, 6);

        // Random traffic, checked only by the model.
        for (int n = 0; n < 3000; n++) begin
            int wa;
            int wb;
            next_cycle();
            rst = ($urandom_range(0, 99) == 0);
            wa  = $urandom_range(0, 31);
            wb  = $urandom_range(0, 15);
            drive_a($urandom_range(0, 1) == 1, wa, $urandom,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 31));
            drive_b($urandom_range(0, 1) == 1, wb, {$urandom, $urandom},
                    $urandom_range(0, 2) == 0, $urandom_range(0, 15));
            for (int p = 0; p < 2; p++)
                a_if.rd_reg[p] = ($urandom_range(0, 3) == 0) ? reg_addr_t'(wa)
                                                             : reg_addr_t'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++)
                b_if.rd_reg[p] = ($urandom_range(0, 3) == 0) ? 4'(wb)
                                                             : 4'($urandom_range(0, 15));
        end
        next_cycle();
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
